// File: rtl/riscv_pkg.sv
// Shared RV32 core constants.
// Fetch-path widths and the default boot address.
package riscv_pkg;

    localparam int RV_PC_WIDTH    = 32;
    localparam int RV_INSTR_WIDTH = 32;
    localparam int RV_INSTR_BYTES = 4;

    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear and occupancy count.
// A pop frees a slot for a push in the same cycle, even when full.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_rdata = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; clear wins over push/pop
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; payload needs no reset
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_rst && !i_clr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetcher with credit-based request issue.
// Stale responses after a redirect are counted out and dropped.
module if_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int                  PC_WIDTH    = RV_PC_WIDTH,
    parameter int                  INSTR_WIDTH = RV_INSTR_WIDTH,
    parameter int                  FIFO_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RV_RESET_PC)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(RV_INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] PC_ALIGN = ~PC_WIDTH'(3);
    localparam logic [CW:0]         CREDITS  = (CW + 1)'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]       r_outstanding;
    logic [CW-1:0]       r_drop_cnt;

    logic [CW-1:0]       w_out_next;
    logic [CW-1:0]       w_drop_next;
    logic [CW-1:0]       w_fifo_count;
    logic                w_fifo_empty;
    logic [EW-1:0]       w_fifo_wdata;
    logic [EW-1:0]       w_fifo_rdata;
    logic [CW:0]         w_inflight;
    logic [PC_WIDTH-1:0] w_redirect_pc;
    logic                w_credit;
    logic                w_req_fire;
    logic                w_rsp_drop;
    logic                w_push;
    logic                w_pop;

    // Requests in flight plus buffered entries may never exceed the buffer,
    // so every response is guaranteed a slot.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_credit   = (w_inflight < CREDITS);

    assign w_redirect_pc = redirect_pc & PC_ALIGN;

    assign imem_req_valid = !areset && !redirect_valid && w_credit;
    assign imem_req_addr  = areset ? RESET_PC : r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop   = redirect_valid || (r_drop_cnt != '0);
    assign w_push       = !areset && imem_rsp_valid && !w_rsp_drop;
    assign w_fifo_wdata = {r_resp_pc, imem_rsp_data};

    assign instr_valid = !areset && !w_fifo_empty;
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign instr_pc    = areset ? '0 : w_fifo_rdata[EW-1 -: PC_WIDTH];
    assign instr       = areset ? '0 : w_fifo_rdata[INSTR_WIDTH-1:0];

    // Fetch and response PCs; a redirect realigns both to the new target
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
            end
        end
    end

    // Next outstanding and drop counts
    always_comb begin
        w_out_next  = r_outstanding;
        w_drop_next = r_drop_cnt;
        if (w_req_fire && !imem_rsp_valid) begin
            w_out_next = r_outstanding + CW'(1);
        end else if (!w_req_fire && imem_rsp_valid) begin
            w_out_next = r_outstanding - CW'(1);
        end
        if (redirect_valid) begin
            w_drop_next = r_outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
            w_drop_next = r_drop_cnt - CW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_clr   (redirect_valid),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with an in-order memory model.
// Memory returns ~addr so data and PC can be cross-checked.
module tb_if_prefetch_unit;

    logic        aclk = 1'b0;
    logic        areset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        z_areset;
    logic        z_req_valid;
    logic [31:0] z_req_addr;
    logic        z_instr_valid;
    logic [31:0] z_instr;
    logic [31:0] z_instr_pc;

    always #5 aclk = ~aclk;

    if_prefetch_unit #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .FIFO_DEPTH  (4),
        .RESET_PC    (32'h0000_0100)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    if_prefetch_unit #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .FIFO_DEPTH  (4),
        .RESET_PC    (32'hFFFF_FFFC)
    ) dut_wrap (
        .aclk           (aclk),
        .areset         (z_areset),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req_valid (z_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (z_req_addr),
        .imem_rsp_valid (1'b0),
        .imem_rsp_data  (32'h0),
        .instr_valid    (z_instr_valid),
        .instr_ready    (1'b1),
        .instr          (z_instr),
        .instr_pc       (z_instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        rst;
        logic        ir;
        logic        rr;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    pend_t pend_q[$];
    vec_t  tbl[18];

    int cyc = 0;
    int lat = 1;
    int n_vec = 0;
    int n_bad = 0;
    int n_hs;

    logic        s_rv;
    logic        s_hs;
    logic [31:0] s_addr;
    logic        s_iv;
    logic [31:0] s_pc;
    logic [31:0] s_in;
    logic        s_zrv;
    logic [31:0] s_zaddr;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, advance memory model after posedge.
    task automatic tick();
        pend_t p;
        @(negedge aclk);
        s_rv    = imem_req_valid;
        s_addr  = imem_req_addr;
        s_hs    = imem_req_valid && imem_req_ready;
        s_iv    = instr_valid;
        s_pc    = instr_pc;
        s_in    = instr;
        s_zrv   = z_req_valid;
        s_zaddr = z_req_addr;
        if (areset) begin
            pend_q.delete();
        end else if (s_hs) begin
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend_q.push_back(p);
        end
        @(posedge aclk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~p.addr;
        end
    endtask

    task automatic do_reset();
        areset         = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic wait_instr(input string name, input logic [31:0] exp_pc,
                              input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            tick();
            if (s_iv) begin
                seen = 1'b1;
                check({name, "_pc"}, s_pc, exp_pc);
                check({name, "_data"}, s_in, ~exp_pc);
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 32'(s_iv), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        areset         = 1'b1;
        z_areset       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h108};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h108};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h108};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h118, 1'b1, 32'h108};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h118, 1'b1, 32'h10C};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h120, 1'b1, 32'h114};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h124, 1'b1, 32'h118};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h124, 1'b1, 32'h11C};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h128, 1'b1, 32'h120};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h12C, 1'b1, 32'h124};

        // Table: reset, release, steady stream, backpressure, full buffer
        lat = 1;
        for (int i = 0; i < 18; i++) begin
            areset         = tbl[i].rst;
            instr_ready    = tbl[i].ir;
            imem_req_ready = tbl[i].rr;
            tick();
            check($sformatf("row%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].e_rv));
            check($sformatf("row%0d_req_addr", i), s_addr, tbl[i].e_addr);
            check($sformatf("row%0d_instr_valid", i), 32'(s_iv), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                check($sformatf("row%0d_instr_pc", i), s_pc, tbl[i].e_pc);
                check($sformatf("row%0d_instr", i), s_in, ~tbl[i].e_pc);
            end else if (tbl[i].rst) begin
                check($sformatf("row%0d_rst_pc", i), s_pc, 32'h0);
                check($sformatf("row%0d_rst_instr", i), s_in, 32'h0);
            end
        end
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;

        // Wrap-around of the fetch address
        tick();
        tick();
        z_areset = 1'b0;
        tick();
        check("wrap_first_valid", 32'(s_zrv), 32'd1);
        check("wrap_first_addr", s_zaddr, 32'hFFFF_FFFC);
        tick();
        check("wrap_second_addr", s_zaddr, 32'h0000_0000);

        // Redirect with three requests outstanding, 3-cycle memory
        lat = 3;
        do_reset();
        tick();
        check("drop_c0_addr", s_addr, 32'h100);
        tick();
        tick();
        check("drop_c2_addr", s_addr, 32'h108);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        check("drop_redir_noreq", 32'(s_rv), 32'd0);
        redirect_valid = 1'b0;
        tick();
        check("drop_new_addr", s_addr, 32'h200);
        check("drop_new_iv", 32'(s_iv), 32'd0);
        wait_instr("drop_first", 32'h200, 20);
        wait_instr("drop_second", 32'h204, 5);

        // Misaligned redirect with a response in the same cycle
        lat = 1;
        do_reset();
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h303;
        tick();
        check("mis_redir_noreq", 32'(s_rv), 32'd0);
        redirect_valid = 1'b0;
        tick();
        check("mis_addr", s_addr, 32'h300);
        check("mis_iv_c4", 32'(s_iv), 32'd0);
        tick();
        check("mis_iv_c5", 32'(s_iv), 32'd0);
        tick();
        check("mis_iv_c6", 32'(s_iv), 32'd1);
        check("mis_pc_c6", s_pc, 32'h300);
        check("mis_data_c6", s_in, ~32'h300);

        // Back-to-back redirects: last target wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        tick();
        redirect_pc = 32'h604;
        tick();
        check("b2b_noreq", 32'(s_rv), 32'd0);
        redirect_valid = 1'b0;
        tick();
        check("b2b_addr", s_addr, 32'h604);
        wait_instr("b2b_first", 32'h604, 10);

        // Full buffer: decode stalled for 10 cycles, then drain in order
        lat         = 1;
        instr_ready = 1'b0;
        do_reset();
        n_hs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_hs) n_hs++;
        end
        check("full_req_count", 32'(n_hs), 32'd4);
        check("full_req_idle", 32'(s_rv), 32'd0);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_instr($sformatf("drain%0d", k), 32'h100 + 32'(4 * k), 6);
        end

        // Reset pulsed with 2 buffered and 2 outstanding
        lat         = 3;
        instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        check("mrst_pre_iv", 32'(s_iv), 32'd1);
        areset = 1'b1;
        tick();
        check("mrst_iv_in_rst", 32'(s_iv), 32'd0);
        check("mrst_rv_in_rst", 32'(s_rv), 32'd0);
        areset = 1'b0;
        tick();
        check("mrst_iv_after", 32'(s_iv), 32'd0);
        check("mrst_rv_after", 32'(s_rv), 32'd1);
        check("mrst_addr_after", s_addr, 32'h100);
        instr_ready = 1'b1;
        wait_instr("mrst_first", 32'h100, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
